// File: rtl/riscorvo_dmem_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : riscorvo_dmem_bridge_if
//  Description : Core-side data-memory request/response bundle for the
//                riscorvo data-memory bridge. Signal suffixes are written
//                from the bridge's point of view (_i into the bridge,
//                _o out of it).
//  Signals     : valid_data_i  request valid, held until ready
//                addr_data_i   byte address
//                write_data_i  store data
//                read_write_i  1 = write, 0 = read
//                mask_data_i   byte enables for writes
//                ready_data_o  one-cycle completion pulse
//                read_data_o   load data, valid with ready_data_o
//                err_o         bus-error pulse, coincident with ready
//  Modports    : master (core side), slave (bridge side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface riscorvo_dmem_bridge_if;
    logic        valid_data_i;
    logic [31:0] addr_data_i;
    logic [31:0] write_data_i;
    logic        read_write_i;
    logic [3:0]  mask_data_i;
    logic        ready_data_o;
    logic [31:0] read_data_o;
    logic        err_o;

    modport master (
        output valid_data_i,
        output addr_data_i,
        output write_data_i,
        output read_write_i,
        output mask_data_i,
        input  ready_data_o,
        input  read_data_o,
        input  err_o
    );

    modport slave (
        input  valid_data_i,
        input  addr_data_i,
        input  write_data_i,
        input  read_write_i,
        input  mask_data_i,
        output ready_data_o,
        output read_data_o,
        output err_o
    );
endinterface
`default_nettype wire

// File: rtl/riscorvo_dmem_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : riscorvo_dmem_bridge
//  Description : Slave bridge between the riscorvo core data port and a
//                single-port synchronous SRAM. One transaction at a time:
//                IDLE -> ACCESS -> WAIT -> RESP -> IDLE, or IDLE -> RESP for
//                addresses outside the RAM window (bus error).
//  Ports       : clock         rising-edge clock
//                reset         asynchronous active-high reset
//                bus           core request/response (slave modport)
//                busy_o        high whenever a transaction is in flight
//                sram_ce_o     SRAM access strobe (ACCESS cycle only)
//                sram_we_o     SRAM write enable
//                sram_be_o     SRAM byte enables
//                sram_addr_o   SRAM word address
//                sram_wdata_o  SRAM write data
//                sram_rdata_i  SRAM read data, READ_LATENCY after strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module riscorvo_dmem_bridge #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 1,
    parameter int          WAIT_STATES  = 0,
    localparam int         ADDR_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clock,
    input  logic                  reset,
    riscorvo_dmem_bridge_if.slave bus,
    output logic                  busy_o,
    output logic                  sram_ce_o,
    output logic                  sram_we_o,
    output logic [3:0]            sram_be_o,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i
);

    // Counter must hold RL+WS and the capture point WS+1.
    localparam int                 c_CNT_W        = $clog2(READ_LATENCY + WAIT_STATES + 2);
    // 33 bits so a 4 GiB window does not wrap to zero.
    localparam logic [32:0]        c_WINDOW_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [c_CNT_W-1:0] c_N_READ       = c_CNT_W'(READ_LATENCY + WAIT_STATES);
    localparam logic [c_CNT_W-1:0] c_N_WRITE      = c_CNT_W'(WAIT_STATES);
    // In WAIT the counter starts at N and steps down once per cycle; it
    // equals WS+1 exactly READ_LATENCY cycles after the ACCESS cycle.
    localparam logic [c_CNT_W-1:0] c_CAPTURE      = c_CNT_W'(WAIT_STATES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [31:0]         w_offset;
    logic                w_in_window;
    logic                w_accept;
    logic                w_ready;
    logic                w_err;
    logic [c_CNT_W-1:0]  w_count_load;

    logic [ADDR_W-1:0]   r_word_addr;
    logic [31:0]         r_wdata;
    logic                r_rw;
    logic [3:0]          r_mask;
    logic                r_err;
    logic [c_CNT_W-1:0]  r_count;
    logic [31:0]         r_rdata;

    // Wrapping subtraction: addresses below the base become huge offsets
    // and therefore fall outside the window.
    assign w_offset     = bus.addr_data_i - BASE_ADDR;
    assign w_in_window  = ({1'b0, w_offset} < c_WINDOW_BYTES);
    assign w_count_load = r_rw ? c_N_WRITE : c_N_READ;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ready     = 1'b0;
        w_err       = 1'b0;
        sram_ce_o   = 1'b0;
        sram_we_o   = 1'b0;
        sram_be_o   = 4'h0;
        busy_o      = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (bus.valid_data_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_in_window ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                sram_ce_o   = 1'b1;
                sram_we_o   = r_rw;
                sram_be_o   = r_rw ? r_mask : 4'hF;
                w_state_nxt = (w_count_load == '0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (r_count == c_CNT_W'(1)) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_ready     = 1'b1;
                w_err       = r_err;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter and load-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_word_addr <= '0;
            r_wdata     <= '0;
            r_rw        <= 1'b0;
            r_mask      <= 4'h0;
            r_err       <= 1'b0;
            r_count     <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_accept) begin
                r_word_addr <= w_offset[ADDR_W+1:2];
                r_wdata     <= bus.write_data_i;
                r_rw        <= bus.read_write_i;
                r_mask      <= bus.mask_data_i;
                r_err       <= ~w_in_window;
                // A faulting load returns zero; a faulting store leaves
                // the last load data untouched.
                if (!w_in_window && !bus.read_write_i) begin
                    r_rdata <= '0;
                end
            end

            if (r_state == S_ACCESS) begin
                r_count <= w_count_load;
            end else if (r_state == S_WAIT) begin
                r_count <= r_count - c_CNT_W'(1);
            end

            if (r_state == S_WAIT && !r_rw && r_count == c_CAPTURE) begin
                r_rdata <= sram_rdata_i;
            end
        end
    end

    assign bus.ready_data_o = w_ready;
    assign bus.err_o        = w_err;
    assign bus.read_data_o  = r_rdata;
    assign sram_addr_o      = r_word_addr;
    assign sram_wdata_o     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_riscorvo_dmem_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_riscorvo_dmem_bridge
//  Description : Self-checking bench for riscorvo_dmem_bridge. Three bridge
//                instances with different base/latency/wait settings, each
//                behind its own behavioural SRAM. Expected timing, strobes
//                and load data come from a word-array memory model and the
//                latency rules of the bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscorvo_dmem_bridge;

    localparam int c_NDUT  = 3;
    localparam int c_DEPTH = 1024;

    function automatic logic [31:0] f_base(input int d);
        return (d == 2) ? 32'h0000_0100 : 32'h0000_0000;
    endfunction
    function automatic int f_rl(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            default: return 3;
        endcase
    endfunction
    function automatic int f_ws(input int d);
        case (d)
            0:       return 0;
            1:       return 3;
            default: return 1;
        endcase
    endfunction
    function automatic logic [31:0] init_word(input int d, input int a);
        return 32'h5A3C_96E1 ^ (32'(a) * 32'h9E37_79B1) ^ (32'(d) << 28);
    endfunction

    logic              clock;
    logic              reset;
    logic [2:0]        valid;
    logic [2:0]        rw;
    logic [31:0]       addr   [c_NDUT];
    logic [31:0]       wdata  [c_NDUT];
    logic [3:0]        mask   [c_NDUT];

    wire  [2:0]        ready;
    wire  [2:0]        err;
    wire  [2:0]        busy;
    wire  [2:0]        ce;
    wire  [2:0]        we;
    wire  [3:0]        be     [c_NDUT];
    wire  [9:0]        saddr  [c_NDUT];
    wire  [31:0]       swdata [c_NDUT];
    wire  [31:0]       rdata  [c_NDUT];

    logic [31:0]       ref_mem    [c_NDUT][c_DEPTH];
    logic [31:0]       last_rdata [c_NDUT];
    int                n_vec;
    int                n_miss;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar i = 0; i < c_NDUT; i++) begin : g_dut
        localparam int c_RL = f_rl(i);
        riscorvo_dmem_bridge_if bus ();
        logic [31:0] mem  [c_DEPTH];
        logic [31:0] pipe [c_RL];

        assign bus.valid_data_i = valid[i];
        assign bus.read_write_i = rw[i];
        assign bus.addr_data_i  = addr[i];
        assign bus.write_data_i = wdata[i];
        assign bus.mask_data_i  = mask[i];
        assign ready[i]         = bus.ready_data_o;
        assign err[i]           = bus.err_o;
        assign rdata[i]         = bus.read_data_o;

        riscorvo_dmem_bridge #(
            .BASE_ADDR    (f_base(i)),
            .DEPTH_WORDS  (c_DEPTH),
            .READ_LATENCY (f_rl(i)),
            .WAIT_STATES  (f_ws(i))
        ) u_dut (
            .clock        (clock),
            .reset        (reset),
            .bus          (bus),
            .busy_o       (busy[i]),
            .sram_ce_o    (ce[i]),
            .sram_we_o    (we[i]),
            .sram_be_o    (be[i]),
            .sram_addr_o  (saddr[i]),
            .sram_wdata_o (swdata[i]),
            .sram_rdata_i (pipe[c_RL-1])
        );

        initial begin
            for (int a = 0; a < c_DEPTH; a++) mem[a] = init_word(i, a);
        end

        // Synchronous SRAM: data for a read strobe appears c_RL cycles
        // later; otherwise the output carries noise.
        always @(posedge clock) begin
            if (ce[i] && we[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[i][b]) mem[saddr[i]][8*b +: 8] <= swdata[i][8*b +: 8];
                end
            end
            pipe[0] <= (ce[i] && !we[i]) ? mem[saddr[i]] : $urandom();
            for (int j = 1; j < c_RL; j++) pipe[j] <= pipe[j-1];
        end
    end

    // One transaction on DUT d. b2b: request is driven right now, in the
    // RESP cycle of the previous one (so one bubble cycle is expected).
    // hold: leave valid high at ready so a b2b request can follow.
    task automatic txn(input int d, input bit is_wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] m,
                       input bit drop, input bit b2b, input bit hold);
        logic [31:0] off_addr;
        logic [31:0] exp_rd;
        logic [9:0]  exp_word;
        logic [3:0]  exp_be;
        bit          inwin;
        bit          exp_ce;
        bit          strobe_ok;
        bit          timing_ok;
        int          n;
        int          off;
        int          lat;
        strobe_ok = 1'b1;
        timing_ok = 1'b1;
        off_addr  = a - f_base(d);
        inwin     = (off_addr < 32'(4 * c_DEPTH));
        n         = is_wr ? f_ws(d) : f_rl(d) + f_ws(d);
        off       = b2b ? 1 : 0;
        lat       = (inwin ? n + 2 : 1) + off;
        exp_word  = off_addr[11:2];
        exp_be    = is_wr ? m : 4'hF;
        if (!inwin) begin
            exp_rd = is_wr ? last_rdata[d] : 32'h0;
        end else if (is_wr) begin
            exp_rd = last_rdata[d];
            for (int b = 0; b < 4; b++) begin
                if (m[b]) ref_mem[d][exp_word][8*b +: 8] = wd[8*b +: 8];
            end
        end else begin
            exp_rd = ref_mem[d][exp_word];
        end
        last_rdata[d] = exp_rd;

        if (!b2b) @(negedge clock);
        valid[d] = 1'b1;
        rw[d]    = is_wr;
        addr[d]  = a;
        wdata[d] = wd;
        mask[d]  = m;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            exp_ce = inwin && (k == off + 1);
            if (ce[d] !== exp_ce || we[d] !== (exp_ce && is_wr) ||
                be[d] !== (exp_ce ? exp_be : 4'h0))
                strobe_ok = 1'b0;
            if (exp_ce && (saddr[d] !== exp_word || (is_wr && swdata[d] !== wd)))
                strobe_ok = 1'b0;
            if (busy[d] !== (k > off) || ready[d] !== (k == lat))
                timing_ok = 1'b0;
            if (k != lat && err[d] !== 1'b0)
                timing_ok = 1'b0;
            if (k == lat) begin
                n_vec++;
                if (err[d] !== !inwin) begin
                    n_miss++;
                    $display("FAIL err dut%0d addr=%h: got %b expected %b", d, a, err[d], !inwin);
                end
                n_vec++;
                if (rdata[d] !== exp_rd) begin
                    n_miss++;
                    $display("FAIL read_data dut%0d addr=%h wr=%0b: got %h expected %h",
                             d, a, is_wr, rdata[d], exp_rd);
                end
                if (!hold) valid[d] = 1'b0;
            end else if (k > off) begin
                // Request inputs are ignored once accepted.
                addr[d]  = $urandom();
                wdata[d] = $urandom();
                mask[d]  = 4'($urandom());
                rw[d]    = 1'($urandom());
                if (drop) valid[d] = 1'b0;
            end
        end
        n_vec++;
        if (!strobe_ok) begin
            n_miss++;
            $display("FAIL sram_strobe dut%0d addr=%h wr=%0b: got addr=%h be=%h expected addr=%h be=%h ce_cycle=%0d",
                     d, a, is_wr, saddr[d], be[d], exp_word, exp_be, inwin ? off + 1 : 0);
        end
        n_vec++;
        if (!timing_ok) begin
            n_miss++;
            $display("FAIL timing dut%0d addr=%h wr=%0b: got busy=%b ready=%b expected ready at cycle %0d",
                     d, a, is_wr, busy[d], ready[d], lat);
        end
        if (!hold) begin
            @(negedge clock);
            n_vec++;
            if (ready[d] !== 1'b0 || busy[d] !== 1'b0 || ce[d] !== 1'b0) begin
                n_miss++;
                $display("FAIL after_resp dut%0d: got ready=%b busy=%b ce=%b expected 0/0/0",
                         d, ready[d], busy[d], ce[d]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        for (int d = 0; d < c_NDUT; d++) begin
            n_vec++;
            if (ready[d] !== 1'b0 || err[d] !== 1'b0 || busy[d] !== 1'b0 || ce[d] !== 1'b0 ||
                we[d] !== 1'b0 || be[d] !== 4'h0 || saddr[d] !== 10'h0 ||
                swdata[d] !== 32'h0 || rdata[d] !== 32'h0) begin
                n_miss++;
                $display("FAIL reset_state dut%0d: got rdy=%b err=%b busy=%b ce=%b be=%h rd=%h expected all zero",
                         d, ready[d], err[d], busy[d], ce[d], be[d], rdata[d]);
            end
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_write_read_default();
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (rdata[0] !== 32'hDEAD_BEEF) begin
            n_miss++;
            $display("FAIL readback_0x10: got %h expected deadbeef", rdata[0]);
        end
    endtask

    task automatic test_wait_states();
        txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        txn(1, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 1'b0);
        txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_out_of_window();
        txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        txn(2, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        txn(2, 1'b0, 32'h0000_00FC, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        txn(2, 1'b0, 32'h0000_1100, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        txn(2, 1'b1, 32'h0000_1100, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 1'b0);
        txn(2, 1'b0, 32'h0000_10FC, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        txn(2, 1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_partial_write();
        logic [31:0] exp;
        exp = (init_word(0, 2) & 32'hFFFF_00FF) | 32'h0000_3300;
        txn(0, 1'b1, 32'h8, 32'h1122_3344, 4'b0010, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (rdata[0] !== exp) begin
            n_miss++;
            $display("FAIL partial_write: got %h expected %h", rdata[0], exp);
        end
        txn(0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_protocol_violation();
        txn(1, 1'b1, 32'h80, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b0, 1'b0);
        txn(1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < c_NDUT; d++) begin
            txn(d, 1'b1, f_base(d) + 32'h20, 32'hA5A5_0000 + 32'(d), 4'hF, 1'b0, 1'b0, 1'b1);
            txn(d, 1'b0, f_base(d) + 32'h20, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
            txn(d, 1'b0, f_base(d) + 32'h2000, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
            txn(d, 1'b0, f_base(d) + 32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_mid(input int d, input int cyc);
        @(negedge clock);
        valid[d] = 1'b1;
        rw[d]    = 1'b0;
        addr[d]  = f_base(d) + 32'h10;
        mask[d]  = 4'h0;
        repeat (cyc) @(negedge clock);
        n_vec++;
        if (ce[d] !== (cyc == 1) || busy[d] !== 1'b1) begin
            n_miss++;
            $display("FAIL pre_reset dut%0d: got ce=%b busy=%b expected ce=%b busy=1",
                     d, ce[d], busy[d], (cyc == 1));
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (ce[d] !== 1'b0 || ready[d] !== 1'b0 || busy[d] !== 1'b0 || rdata[d] !== 32'h0) begin
            n_miss++;
            $display("FAIL async_reset dut%0d: got ce=%b ready=%b busy=%b rd=%h expected all zero",
                     d, ce[d], ready[d], busy[d], rdata[d]);
        end
        valid[d] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int e = 0; e < c_NDUT; e++) last_rdata[e] = 32'h0;
        txn(d, 1'b0, f_base(d) + 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit          chain;
        bit          hold;
        for (int d = 0; d < c_NDUT; d++) begin
            chain = 1'b0;
            for (int t = 0; t < 25; t++) begin
                if ($urandom_range(0, 7) == 0) a = $urandom();
                else a = f_base(d) + (32'($urandom_range(0, c_DEPTH - 1)) << 2)
                         + 32'($urandom_range(0, 3));
                hold = (t != 24) && ($urandom_range(0, 3) == 0);
                txn(d, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom()),
                    ($urandom_range(0, 9) == 0), chain, hold);
                chain = hold;
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b1;
        valid  = '0;
        rw     = '0;
        for (int d = 0; d < c_NDUT; d++) begin
            addr[d]       = 32'h0;
            wdata[d]      = 32'h0;
            mask[d]       = 4'h0;
            last_rdata[d] = 32'h0;
            for (int a = 0; a < c_DEPTH; a++) ref_mem[d][a] = init_word(d, a);
        end
        test_reset();
        test_write_read_default();
        test_wait_states();
        test_out_of_window();
        test_partial_write();
        test_protocol_violation();
        test_back_to_back();
        test_reset_mid(0, 1);
        test_reset_mid(1, 2);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscorvo_dmem_bridge.md
Name: riscorvo_dmem_bridge

Overview:
Downstream slave for the riscorvo core data-memory port. Accepts one valid/ready transaction at a time and converts it into strobes for a single-port synchronous SRAM with fixed read latency and optional wait states. Flags out-of-window accesses with a bus error. Sits between the core's data interface and on-chip data RAM.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of the RAM window
DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two); ADDR_W = clog2(DEPTH_WORDS)
READ_LATENCY, 1, cycles from SRAM strobe to valid sram_rdata_i (>=1)
WAIT_STATES, 0, extra stall cycles added to every in-window access (0..15)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
valid_data_i  in  1  core request valid, held until ready
ready_data_o  out  1  one-cycle completion pulse
addr_data_i  in  32  byte address
write_data_i  in  32  store data
read_write_i  in  1  1 = write, 0 = read
mask_data_i  in  4  byte enables for writes
read_data_o  out  32  load data, valid with ready_data_o
err_o  out  1  bus-error pulse, coincident with ready_data_o
busy_o  out  1  high whenever state != IDLE
sram_ce_o  out  1  SRAM access strobe
sram_we_o  out  1  SRAM write enable
sram_be_o  out  4  SRAM byte enables
sram_addr_o  out  ADDR_W  SRAM word address
sram_wdata_o  out  32  SRAM write data
sram_rdata_i  in  32  SRAM read data

Behaviour:
- Reset (async assert): state=IDLE, counter=0. All outputs 0, including read_data_o and sram_* outputs. sram_ce_o drops immediately, even mid-access.
- FSM: IDLE -> ACCESS -> WAIT -> RESP -> IDLE. Error path: IDLE -> RESP.
- IDLE: on clock edge with valid_data_i=1, latch addr, wdata, rw and mask. In-window is (addr - BASE_ADDR) < 4*DEPTH_WORDS, unsigned 32-bit compare. In-window -> ACCESS; otherwise -> RESP with error flag set.
- addr[1:0] ignored (core handles alignment). sram_addr_o = (addr - BASE_ADDR)[ADDR_W+1:2].
- ACCESS (exactly 1 cycle): sram_ce_o=1, sram_we_o=rw, sram_addr_o and sram_wdata_o from latched values. sram_be_o = mask for writes, 4'hF for reads. A write with mask 0000 still strobes with be=0; memory is unchanged.
- WAIT: counter loads N at ACCESS exit. N = READ_LATENCY+WAIT_STATES for reads, WAIT_STATES for writes. Counter decrements each cycle; exit to RESP when it reaches 0. If N=0, go ACCESS -> RESP directly.
- Read capture: sram_rdata_i is registered into read_data_o at the end of the cycle READ_LATENCY cycles after ACCESS.
- Read latency (edge-count from accept edge to RESP cycle): READ_LATENCY+WAIT_STATES+2. Write latency: WAIT_STATES+2.
- RESP (exactly 1 cycle): ready_data_o=1; err_o=1 if error path. On error read, read_data_o=0 during RESP. Next state IDLE.
- Back-to-back: a new request is sampled no earlier than the IDLE cycle following RESP (one bubble minimum).
- read_data_o holds its last value until the next read capture or error-read clear. Writes do not alter it.
- Request inputs changing while busy are ignored; the latched copy is used.
- valid_data_i dropping before ready is a protocol violation. The bridge still completes the transaction (write committed) and pulses ready.
- sram_* outputs are 0 outside ACCESS, except sram_addr_o/sram_wdata_o, which may hold.

Test Plan:
1. Default params, write addr=0x10, data=0xDEADBEEF, mask=1111 -> ACCESS cycle shows ce=1, we=1, addr=4, be=F; ready pulses 2 cycles after accept; err_o=0.
2. Read addr=0x10 after test 1, SRAM model RL=1 -> ready 3 cycles after accept with read_data_o=0xDEADBEEF; sram_be_o=F, we=0.
3. WAIT_STATES=3, READ_LATENCY=2: read -> ready exactly 7 cycles after accept; write -> 5 cycles; busy_o high throughout, single-cycle ready.
4. Read addr=0x1000 (DEPTH 1024) and addr=BASE_ADDR-4 with BASE_ADDR=0x100 -> no sram_ce_o, ready+err_o 1 cycle after accept, read_data_o=0.
5. Partial write mask=0010 data=0x11223344 to addr=0x8, then read -> sram_be_o=0010; RAM model byte1=0x33 only, other bytes keep prior contents.
6. Assert reset during WAIT of a read -> sram_ce_o, ready_data_o, busy_o, read_data_o all 0 immediately; after release, a fresh read completes normally.
